// File: rtl/rat_arf_pkg.sv
// rat_arf_pkg
//   Shared definitions for the register alias table / architected register
//   file and the blocks that talk to it (ROB, reservation stations).
//   Contents: register-file geometry constants, index/tag/data typedefs and
//   the hardwired-zero register index.

package rat_arf_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0]     rob_tag_t;
  typedef logic [DATA_W-1:0]    data_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rat_src_lookup.sv
// rat_src_lookup
//   Combinational operand lookup for one source register. Resolves the
//   operand to either a ready value (architected value or a same-cycle
//   commit bypass) or the ROB tag that will eventually produce it.
// Ports:
//   i_src_reg              source architected register
//   i_arf_val/i_busy/i_map current state of that register
//   i_commit1/_addr/_val/_tag   first commit port (ROB head)
//   i_commit2/_addr2/_val2/_tag2 second commit port (tag = head tag + 1)
//   o_ready/o_val/o_tag    resolved operand (val 0 if not ready, tag 0 if ready)

module rat_src_lookup
  import rat_arf_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_src_reg,
  input  logic [DATA_W-1:0]    i_arf_val,
  input  logic                 i_busy,
  input  logic [TAG_W-1:0]     i_map,
  input  logic                 i_commit1,
  input  logic [REG_IDX_W-1:0] i_commit_addr,
  input  logic [DATA_W-1:0]    i_commit_val,
  input  logic [TAG_W-1:0]     i_commit_tag,
  input  logic                 i_commit2,
  input  logic [REG_IDX_W-1:0] i_commit_addr2,
  input  logic [DATA_W-1:0]    i_commit_val2,
  input  logic [TAG_W-1:0]     i_commit_tag2,
  output logic                 o_ready,
  output logic [DATA_W-1:0]    o_val,
  output logic [TAG_W-1:0]     o_tag
);

  // A commit only bypasses when it is the exact producer the mapping waits
  // on; an older commit to a re-renamed register must not satisfy it.
  always_comb begin
    o_ready = 1'b1;
    o_val   = '0;
    o_tag   = '0;
    if (i_src_reg == REG_ZERO) begin
      o_val = '0;
    end else if (!i_busy) begin
      o_val = i_arf_val;
    end else if (i_commit1 && (i_commit_addr == i_src_reg) &&
                 (i_commit_tag == i_map)) begin
      o_val = i_commit_val;
    end else if (i_commit2 && (i_commit_addr2 == i_src_reg) &&
                 (i_commit_tag2 == i_map)) begin
      o_val = i_commit_val2;
    end else begin
      o_ready = 1'b0;
      o_tag   = i_map;
    end
  end

endmodule

// File: rtl/rat_arf.sv
// rat_arf
//   Register alias table plus architected register file. On issue it records
//   which ROB tag produces each destination; on commit it writes the
//   architected value and retires the mapping if still current. Supplies
//   both issue source operands as ready values or pending ROB tags.
// Ports:
//   clk, rst (async, active-low)
//   write_rat/dest_reg/tag          rename from issue
//   src1_reg/src2_reg               source lookups
//   srcN_ready/srcN_val/srcN_tag    resolved operands
//   commit1/commit_addr/commit_val/commit_tag   first commit (ROB head)
//   commit2/commit_addr2/commit_val2            second commit (head tag + 1)
//   flush                           squash all speculative mappings

module rat_arf
  import rat_arf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_rat,
  input  logic [REG_IDX_W-1:0] dest_reg,
  input  logic [TAG_W-1:0]     tag,
  input  logic [REG_IDX_W-1:0] src1_reg,
  input  logic [REG_IDX_W-1:0] src2_reg,
  output logic                 src1_ready,
  output logic [DATA_W-1:0]    src1_val,
  output logic [TAG_W-1:0]     src1_tag,
  output logic                 src2_ready,
  output logic [DATA_W-1:0]    src2_val,
  output logic [TAG_W-1:0]     src2_tag,
  input  logic                 commit1,
  input  logic [REG_IDX_W-1:0] commit_addr,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic                 commit2,
  input  logic [REG_IDX_W-1:0] commit_addr2,
  input  logic [DATA_W-1:0]    commit_val2,
  input  logic                 flush
);

  data_t               r_arf [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  rob_tag_t            r_map [NUM_REGS];

  rob_tag_t w_commit_tag2;

  // The second commit is always the entry right behind the ROB head, so its
  // tag is head + 1, wrapping naturally at TAG_W bits.
  assign w_commit_tag2 = commit_tag + rob_tag_t'(1);

  // Register 0 never holds state; its slot stays at reset values. Priority
  // per register: flush clears everything, then a rename installs a new
  // mapping, then a commit retires the mapping only if the tag still matches.
  // Commit 2 is written after commit 1 so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_arf[i] <= '0;
        r_map[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit1 && (commit_addr == reg_idx_t'(i)))
          r_arf[i] <= commit_val;
        if (commit2 && (commit_addr2 == reg_idx_t'(i)))
          r_arf[i] <= commit_val2;

        if (flush) begin
          r_busy[i] <= 1'b0;
        end else if (write_rat && (dest_reg == reg_idx_t'(i))) begin
          r_busy[i] <= 1'b1;
          r_map[i]  <= tag;
        end else if ((commit1 && (commit_addr == reg_idx_t'(i)) &&
                      (commit_tag == r_map[i])) ||
                     (commit2 && (commit_addr2 == reg_idx_t'(i)) &&
                      (w_commit_tag2 == r_map[i]))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  rat_src_lookup u_src1 (
    .i_src_reg      (src1_reg),
    .i_arf_val      (r_arf[src1_reg]),
    .i_busy         (r_busy[src1_reg]),
    .i_map          (r_map[src1_reg]),
    .i_commit1      (commit1),
    .i_commit_addr  (commit_addr),
    .i_commit_val   (commit_val),
    .i_commit_tag   (commit_tag),
    .i_commit2      (commit2),
    .i_commit_addr2 (commit_addr2),
    .i_commit_val2  (commit_val2),
    .i_commit_tag2  (w_commit_tag2),
    .o_ready        (src1_ready),
    .o_val          (src1_val),
    .o_tag          (src1_tag)
  );

  rat_src_lookup u_src2 (
    .i_src_reg      (src2_reg),
    .i_arf_val      (r_arf[src2_reg]),
    .i_busy         (r_busy[src2_reg]),
    .i_map          (r_map[src2_reg]),
    .i_commit1      (commit1),
    .i_commit_addr  (commit_addr),
    .i_commit_val   (commit_val),
    .i_commit_tag   (commit_tag),
    .i_commit2      (commit2),
    .i_commit_addr2 (commit_addr2),
    .i_commit_val2  (commit_val2),
    .i_commit_tag2  (w_commit_tag2),
    .o_ready        (src2_ready),
    .o_val          (src2_val),
    .o_tag          (src2_tag)
  );

endmodule

// File: tb/tb_rat_arf.sv
// tb_rat_arf
//   Directed testbench for rat_arf: rename, commit bypass, stale commits,
//   dual commit with tag wrap, rename/commit collision, flush and reset.

module tb_rat_arf;

  logic        clk;
  logic        rst;
  logic        write_rat;
  logic [4:0]  dest_reg;
  logic [4:0]  tag;
  logic [4:0]  src1_reg;
  logic [4:0]  src2_reg;
  logic        src1_ready;
  logic [31:0] src1_val;
  logic [4:0]  src1_tag;
  logic        src2_ready;
  logic [31:0] src2_val;
  logic [4:0]  src2_tag;
  logic        commit1;
  logic [4:0]  commit_addr;
  logic [31:0] commit_val;
  logic [4:0]  commit_tag;
  logic        commit2;
  logic [4:0]  commit_addr2;
  logic [31:0] commit_val2;
  logic        flush;

  int checkCount = 0;
  int errorCount = 0;

  rat_arf dut (
    .clk          (clk),
    .rst          (rst),
    .write_rat    (write_rat),
    .dest_reg     (dest_reg),
    .tag          (tag),
    .src1_reg     (src1_reg),
    .src2_reg     (src2_reg),
    .src1_ready   (src1_ready),
    .src1_val     (src1_val),
    .src1_tag     (src1_tag),
    .src2_ready   (src2_ready),
    .src2_val     (src2_val),
    .src2_tag     (src2_tag),
    .commit1      (commit1),
    .commit_addr  (commit_addr),
    .commit_val   (commit_val),
    .commit_tag   (commit_tag),
    .commit2      (commit2),
    .commit_addr2 (commit_addr2),
    .commit_val2  (commit_val2),
    .flush        (flush)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every DUT input for one cycle of stimulus.
  task automatic applyStimulus(
    input logic        wr,   input logic [4:0]  dst,  input logic [4:0] tg,
    input logic        c1,   input logic [4:0]  ca,   input logic [31:0] cv,
    input logic [4:0]  ct,   input logic        c2,   input logic [4:0] ca2,
    input logic [31:0] cv2,  input logic        fl,
    input logic [4:0]  s1,   input logic [4:0]  s2);
    write_rat    = wr;
    dest_reg     = dst;
    tag          = tg;
    commit1      = c1;
    commit_addr  = ca;
    commit_val   = cv;
    commit_tag   = ct;
    commit2      = c2;
    commit_addr2 = ca2;
    commit_val2  = cv2;
    flush        = fl;
    src1_reg     = s1;
    src2_reg     = s2;
  endtask

  // Idle cycle apart from the two source lookups.
  task automatic lookupOnly(input logic [4:0] s1, input logic [4:0] s2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic checkSrc1(input string name, input logic rdy,
                           input logic [31:0] val, input logic [4:0] tg);
    checkOutput({name, ".src1_ready"}, {31'd0, src1_ready}, {31'd0, rdy});
    checkOutput({name, ".src1_val"},   src1_val, val);
    checkOutput({name, ".src1_tag"},   {27'd0, src1_tag}, {27'd0, tg});
  endtask

  task automatic checkSrc2(input string name, input logic rdy,
                           input logic [31:0] val, input logic [4:0] tg);
    checkOutput({name, ".src2_ready"}, {31'd0, src2_ready}, {31'd0, rdy});
    checkOutput({name, ".src2_val"},   src2_val, val);
    checkOutput({name, ".src2_tag"},   {27'd0, src2_tag}, {27'd0, tg});
  endtask

  // Inputs change 1 unit after the rising edge; outputs are checked 1 unit
  // later, well clear of the next edge that consumes the stimulus.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    lookupOnly(5, 0);
    #2;
    $display("[TB] reset state");
    checkSrc1("reset_r5", 1, 32'h0, 0);
    checkSrc2("reset_r0", 1, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Rename r3 -> 7, then commit it with a same-cycle bypass.
    nextCycle(); applyStimulus(1, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); lookupOnly(3, 0); #1;
    checkSrc1("r3_pending", 0, 32'h0, 7);
    checkSrc2("r0_during_pending", 1, 32'h0, 0);
    applyStimulus(0, 0, 0, 1, 3, 32'hDEAD, 7, 0, 0, 0, 0, 3, 0); #1;
    checkSrc1("r3_bypass", 1, 32'hDEAD, 0);
    nextCycle(); lookupOnly(3, 0); #1;
    checkSrc1("r3_arf", 1, 32'hDEAD, 0);

    // r4 renamed twice; committing the older tag must not free it.
    applyStimulus(1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); applyStimulus(1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0, 1, 4, 32'h11, 2, 0, 0, 0, 0, 4, 0); #1;
    checkSrc1("r4_stale_commit_no_bypass", 0, 32'h0, 9);
    nextCycle(); lookupOnly(4, 0); #1;
    checkSrc1("r4_still_pending", 0, 32'h0, 9);

    // Dual commit to r6 with head tag 31; second tag wraps to 0.
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0, 1, 6, 32'hA, 31, 1, 6, 32'hB, 0, 6, 6); #1;
    checkSrc1("r6_wrap_bypass", 1, 32'hB, 0);
    nextCycle(); lookupOnly(6, 0); #1;
    checkSrc1("r6_dual_commit_arf", 1, 32'hB, 0);

    // Rename and commit to r8 in the same cycle: rename wins the mapping.
    applyStimulus(1, 8, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); applyStimulus(1, 8, 12, 1, 8, 32'h55, 5, 0, 0, 0, 0, 8, 0); #1;
    checkSrc1("r8_pre_rename_bypass", 1, 32'h55, 0);
    nextCycle(); lookupOnly(8, 0); #1;
    checkSrc1("r8_new_mapping", 0, 32'h0, 12);

    // Outstanding r1/r2 renames, then flush with a competing rename of r9.
    applyStimulus(1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); applyStimulus(1, 2, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); lookupOnly(1, 2); #1;
    checkSrc1("r1_pending", 0, 32'h0, 20);
    checkSrc2("r2_pending", 0, 32'h0, 21);
    applyStimulus(1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    nextCycle(); lookupOnly(1, 2); #1;
    checkSrc1("r1_after_flush", 1, 32'h0, 0);
    checkSrc2("r2_after_flush", 1, 32'h0, 0);
    lookupOnly(9, 8); #1;
    checkSrc1("r9_flush_beats_rename", 1, 32'h0, 0);
    checkSrc2("r8_arf_after_flush", 1, 32'h55, 0);
    lookupOnly(4, 6); #1;
    checkSrc1("r4_arf_after_flush", 1, 32'h11, 0);
    checkSrc2("r6_arf_after_flush", 1, 32'hB, 0);

    // Rename and commit targeting register 0 leave it untouched.
    applyStimulus(1, 0, 15, 1, 0, 32'hBEEF, 15, 0, 0, 0, 0, 0, 0);
    nextCycle(); lookupOnly(0, 0); #1;
    checkSrc1("r0_ignores_writes", 1, 32'h0, 0);

    // Flush with a same-cycle commit still writes the architected value.
    applyStimulus(1, 10, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0, 1, 10, 32'h77, 4, 0, 0, 0, 1, 0, 0);
    nextCycle(); lookupOnly(10, 0); #1;
    checkSrc1("r10_flush_commit", 1, 32'h77, 0);

    // Asynchronous reset in the middle of operation discards everything.
    applyStimulus(1, 11, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); lookupOnly(11, 3); #1;
    checkSrc1("r11_pending_before_reset", 0, 32'h0, 6);
    rst = 1'b0; #1;
    checkSrc1("r11_after_reset", 1, 32'h0, 0);
    checkSrc2("r3_after_reset", 1, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rat_arf.md
Name: rat_arf

Overview:
- Register alias table plus architected register file.
- Sits between decode/issue and the reorder buffer.
- On issue, records which ROB tag will produce each destination register. On ROB commit, writes the architected value and retires the mapping.
- Supplies source operands to issue as either a ready value or a pending ROB tag. This is the consumer end of the ROB's rename and commit interface.

Parameters:
- NUM_REGS, 32, architected registers; register 0 is hardwired zero.
- DATA_W, 32, register data width.
- TAG_W, 5, ROB tag width; must equal log2 of the ROB depth.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- write_rat  input  1  rename enable; the ROB issue was accepted this cycle.
- dest_reg  input  5  destination architected register of the issuing instruction.
- tag  input  TAG_W  ROB tag allocated to the issuing instruction.
- src1_reg  input  5  source 1 architected register.
- src2_reg  input  5  source 2 architected register.
- src1_ready  output  1  1 = src1_val is valid; 0 = wait on src1_tag.
- src1_val  output  DATA_W  source 1 value (0 when not ready).
- src1_tag  output  TAG_W  ROB tag producing source 1 (0 when ready).
- src2_ready  output  1  as src1_ready, for source 2.
- src2_val  output  DATA_W  as src1_val, for source 2.
- src2_tag  output  TAG_W  as src1_tag, for source 2.
- commit1  input  1  first commit valid.
- commit_addr  input  5  first commit destination register.
- commit_val  input  DATA_W  first commit value.
- commit_tag  input  TAG_W  ROB tag of the first commit (ROB head).
- commit2  input  1  second commit valid; asserted only together with commit1.
- commit_addr2  input  5  second commit destination register.
- commit_val2  input  DATA_W  second commit value.
- flush  input  1  squash all speculative mappings.

Behaviour:
- State per register r: arf[r] (DATA_W bits), busy[r] (1 bit), map[r] (TAG_W bits).
- Reset (rst=0, asynchronous): all arf=0, busy=0, map=0. Outputs therefore read ready=1, val=0, tag=0. Reset mid-operation discards all mappings.
- Lookup is combinational from current state, evaluated per source in this order:
  - Register 0: ready=1, val=0.
  - busy=0: ready=1, val=arf[r].
  - busy=1 and commit1, commit_addr=r, commit_tag=map[r]: ready=1, val=commit_val (commit bypass).
  - busy=1 and commit2, commit_addr2=r, (commit_tag+1) mod 2^TAG_W = map[r]: ready=1, val=commit_val2.
  - Otherwise: ready=0, val=0, tag=map[r].
- Sources always see pre-rename state. An instruction whose source equals its own dest sees the old mapping.
- Rename (posedge): if write_rat and dest_reg!=0, set busy[dest_reg]=1 and map[dest_reg]=tag. Rename to register 0 is ignored.
- Commit1 (posedge):
  - If commit_addr!=0, write commit_val to arf[commit_addr].
  - If busy and map matches commit_tag, clear busy.
  - If map does not match, a younger rename is outstanding: busy stays set, map is unchanged.
- Commit2: same as commit1, with tag = (commit_tag+1) mod 2^TAG_W. Tag arithmetic wraps (tag 31 -> 0).
- Same-cycle conflicts:
  - Both commits to the same addr: commit_val2 lands in arf; busy clears if either tag matches current map.
  - Rename and commit to the same register: rename wins. busy=1 and map=new tag; the arf write still happens.
- flush (posedge): all busy cleared. Flush overrides a same-cycle rename (no mapping installed). Same-cycle commits still write arf.
- Latency:
  - Rename is visible to lookups on the cycle after write_rat.
  - Commit value is visible the same cycle via bypass, and from arf the next cycle.
- No handshakes: the ROB gates write_rat with its own full flag, so rename is never refused here.

Decomposition:
- Shared package:
  - Constants: NUM_REGS, DATA_W, TAG_W, REG_ZERO=0.
  - Typedefs: reg_idx_t (5 bits), rob_tag_t (TAG_W bits), data_t (DATA_W bits).
  - These are shared with the ROB and reservation stations.
- One sub-module, rat_src_lookup: the combinational per-source lookup and bypass. Instantiated twice (src1, src2).

Test Plan:
- Reset, then read src1=5, src2=0: both ready=1, val=0. Register 0 reads ready=1, val=0 in all later scenarios.
- Rename r3 -> tag 7. Next cycle src1=3 gives ready=0, tag=7. Commit1 addr=3, tag=7, val=0xDEAD gives src1 ready=1, val=0xDEAD that same cycle; next cycle busy cleared and arf[3]=0xDEAD.
- Rename r4 -> tag 2, then r4 -> tag 9. Commit addr=4, tag=2, val=0x11 gives arf[4]=0x11, but src r4 still ready=0, tag=9.
- Dual commit, commit_tag=31: commit1 addr=6, val=0xA; commit2 addr=6, val=0xB, with r6 mapped to tag 0. Result: arf[6]=0xB, busy[6]=0 (wrap 31+1=0).
- Same cycle: rename r8 -> tag 12 and commit r8 with matching old tag 5, val=0x55. Result: arf[8]=0x55, busy[8]=1, map=12.
- Renames of r1 and r2 outstanding. Flush together with write_rat r9 -> tag 3. Next cycle r1, r2, r9 all read ready=1 with arf values.
